// File: rtl/adder_16b_rr_arb.sv
// Two requesters share one 16-bit parallel-prefix adder behind a round-robin arbiter.
// A single result register with valid/ready handshake allows one result per cycle.

module adder_16b_6l (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    logic [15:0] p_bit;
    logic [15:0] g_acc;
    logic [15:0] p_acc;
    logic [15:0] g_nxt;
    logic [15:0] p_nxt;

    // Kogge-Stone prefix tree: four combine levels at spans 1, 2, 4, 8; carry-in is zero.
    always_comb begin
        // NOTE: blocking assignments here so each level reads the previous level's value in order.
        p_bit = a_i ^ b_i;
        g_acc = a_i & b_i;
        p_acc = p_bit;
        g_nxt = g_acc;
        p_nxt = p_acc;
        for (int lvl = 0; lvl < 4; lvl++) begin
            g_nxt = g_acc;
            p_nxt = p_acc;
            for (int i = (1 << lvl); i < 16; i++) begin
                g_nxt[i] = g_acc[i] | (p_acc[i] & g_acc[i - (1 << lvl)]);
                p_nxt[i] = p_acc[i] & p_acc[i - (1 << lvl)];
            end
            g_acc = g_nxt;
            p_acc = p_nxt;
        end
        sum_o  = p_bit ^ {g_acc[14:0], 1'b0};
        cout_o = g_acc[15];
    end
endmodule

module adder_16b_rr_arb #(
    parameter int PRIO_RESET = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req1_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_sum,
    output logic        res_cout,
    output logic        res_id,
    output logic [15:0] ops0_cnt,
    output logic [15:0] ops1_cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e      state_q;
    logic [15:0] sum_q;
    logic        cout_q;
    logic        id_q;
    logic        last_served_q;
    logic [15:0] ops0_q;
    logic [15:0] ops1_q;

    logic        can_accept;
    logic        grant_vld;
    logic        grant_id;
    logic        xfer;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] sum_d;
    logic        cout_d;

    assign can_accept = (state_q == EMPTY) || res_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant_vld = req0_valid || req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_served_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Reset blocks acceptance so nothing is lost in a cycle that is being cleared.
    assign xfer       = grant_vld && can_accept && !rst;
    assign req0_ready = xfer && (grant_id == 1'b0);
    assign req1_ready = xfer && (grant_id == 1'b1);

    assign op_a = grant_id ? req1_a : req0_a;
    assign op_b = grant_id ? req1_b : req0_b;

    adder_16b_6l u_adder (
        .a_i    (op_a),
        .b_i    (op_b),
        .sum_o  (sum_d),
        .cout_o (cout_d)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q       <= EMPTY;
            sum_q         <= 16'h0000;
            cout_q        <= 1'b0;
            id_q          <= 1'b0;
            last_served_q <= (PRIO_RESET == 0);
            ops0_q        <= 16'h0000;
            ops1_q        <= 16'h0000;
        end else if (xfer) begin
            state_q       <= FULL;
            sum_q         <= sum_d;
            cout_q        <= cout_d;
            id_q          <= grant_id;
            last_served_q <= grant_id;
            if (grant_id) begin
                ops1_q <= ops1_q + 16'd1;
            end else begin
                ops0_q <= ops0_q + 16'd1;
            end
        end else if (state_q == FULL && res_ready) begin
            state_q <= EMPTY;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;
    assign ops0_cnt  = ops0_q;
    assign ops1_cnt  = ops1_q;
endmodule
